// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Pipeline register between decode (ID) and execute (EX) of the 5-stage
// MIPS datapath. It captures the decoded control bundle, the register-file
// operands, the sign-extended immediate, the register specifiers and PC+4.
// It also detects load-use hazards and inserts a bubble when it finds one.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   id_opcode             instruction[31:26] of the ID instruction
//   id_<ctrl>             control bits from the main decoder
//   id_rs_data/rt_data    register-file read data
//   id_imm                instruction[15:0]
//   id_rs/rt/rd           register specifiers
//   id_pc4                PC+4 of the ID instruction
//   flush                 branch/jump taken: kill the ID instruction
//   hold                  downstream stall: freeze this register
//   ex_*                  registered copies of the id_* values
//   ex_imm_ext            sign-extended immediate
//   ex_valid              EX holds a real instruction
//   stall_out             hold PC and IF/ID this cycle (combinational)
//   bubble_count          hazard bubbles inserted, saturating
//
// Flow control: there is no valid/ready pair. stall_out tells upstream to
// keep the PC and IF/ID unchanged for this cycle. hold tells this stage to
// keep every register as it is. Upstream must sample stall_out in the same
// cycle, because it depends on the ID inputs and on the current EX contents.
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        id_opcode,
  input  logic              id_reg_dst,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic [1:0]        id_jump,
  input  logic [1:0]        id_branch,
  input  logic [1:0]        id_mem_read,
  input  logic [1:0]        id_mem_write,
  input  logic [1:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_reg_dst,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [1:0]        ex_jump,
  output logic [1:0]        ex_branch,
  output logic [1:0]        ex_mem_read,
  output logic [1:0]        ex_mem_write,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm_ext,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_pc4,
  output logic              ex_valid,
  output logic              stall_out,
  output logic [CNT_W-1:0]  bubble_count
);

  logic uses_rs;
  logic uses_rt;
  logic load_use;

  // rt is a source operand for R-type and for the stores (sw, sb, sh).
  // rs is a source for every opcode except j, jal and lui.
  always_comb begin
    uses_rt = 1'b0;
    uses_rs = 1'b1;
    case (id_opcode)
      6'b000000, 6'b101011, 6'b101000, 6'b101001: uses_rt = 1'b1;
      default:                                    uses_rt = 1'b0;
    endcase
    case (id_opcode)
      6'b000010, 6'b000011, 6'b001111: uses_rs = 1'b0;
      default:                         uses_rs = 1'b1;
    endcase
  end

  // A load in EX whose destination is read in ID. Register $0 is excluded
  // because it is hardwired to zero.
  assign load_use = ex_valid && (ex_mem_read != 2'b00) && (ex_rt != '0) &&
                    ((uses_rs && (ex_rt == id_rs)) ||
                     (uses_rt && (ex_rt == id_rt)));

  assign stall_out = load_use | hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_reg_dst    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_jump       <= '0;
      ex_branch     <= '0;
      ex_mem_read   <= '0;
      ex_mem_write  <= '0;
      ex_alu_op     <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm_ext    <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_pc4        <= '0;
      ex_valid      <= 1'b0;
      bubble_count  <= '0;
    end else if (hold) begin
      // Freeze everything. A hazard seen during hold is not counted here.
      // It is counted on the edge that actually inserts the bubble.
    end else if (flush || load_use) begin
      // A bubble is all zeros, so it has no architectural side effects.
      ex_reg_dst    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_jump       <= '0;
      ex_branch     <= '0;
      ex_mem_read   <= '0;
      ex_mem_write  <= '0;
      ex_alu_op     <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm_ext    <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_pc4        <= '0;
      ex_valid      <= 1'b0;
      // The bubble is counted only when the hazard caused it. A bubble that
      // a flush causes is not counted, even when a hazard is present too.
      if (!flush && (bubble_count != {CNT_W{1'b1}}))
        bubble_count <= bubble_count + 1'b1;
    end else begin
      ex_reg_dst    <= id_reg_dst;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_alu_src    <= id_alu_src;
      ex_reg_write  <= id_reg_write;
      ex_jump       <= id_jump;
      ex_branch     <= id_branch;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_alu_op     <= id_alu_op;
      ex_rs_data    <= id_rs_data;
      ex_rt_data    <= id_rt_data;
      ex_imm_ext    <= {{(DATA_W-16){id_imm[15]}}, id_imm};
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      ex_pc4        <= id_pc4;
      ex_valid      <= 1'b1;
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (ID) and execute (EX) of the 5-stage MIPS datapath.
- Captures the decoded control bundle from the main control decoder, register-file operands, sign-extended immediate, register specifiers and PC+4.
- Contains load-use hazard detection: it inserts bubbles into EX and stalls PC and IF/ID.
- Also handles branch/jump flush, downstream hold and a saturating bubble counter.

Parameters:
- DATA_W, 32, width of operands, PC and immediate
- REG_W, 5, register specifier width
- CNT_W, 16, bubble counter width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- id_opcode  input  6  instruction[31:26] of the instruction in ID
- id_reg_dst, id_mem_to_reg, id_alu_src, id_reg_write  input  1 each  control from decoder
- id_jump, id_branch, id_mem_read, id_mem_write, id_alu_op  input  2 each  control from decoder
- id_rs_data, id_rt_data  input  DATA_W  register-file read data
- id_imm  input  16  instruction[15:0]
- id_rs, id_rt, id_rd  input  REG_W  instruction fields
- id_pc4  input  DATA_W  PC+4 of the ID instruction
- flush  input  1  branch/jump taken; kill the ID instruction
- hold  input  1  downstream stall; freeze this register
- ex_* outputs  same widths as id_* counterparts  registered copies (ex_reg_dst … ex_pc4, ex_rs, ex_rt, ex_rd)
- ex_imm_ext  output  DATA_W  sign-extended immediate
- ex_valid  output  1  EX holds a real instruction
- stall_out  output  1  combinational; hold PC and IF/ID this cycle
- bubble_count  output  CNT_W  number of hazard bubbles inserted, saturating

Behaviour:
- Reset (async, active-high):
  - all ex_* outputs cleared to 0, ex_valid=0, bubble_count=0.
  - Reset asserted mid-stall discards the pending instruction. After release, the first edge loads normally.
- Register source uses: uses_rt = 1 for opcode 000000, 101011, 101000 and 101001. uses_rs = 1 for every opcode except 000010, 000011 and 001111.
- Hazard:
  - load_use = ex_valid & (ex_mem_read != 0) & (ex_rt != 0) & ((uses_rs & ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
  - Register $0 never causes a hazard.
- stall_out = load_use | hold. It is combinational and there is no extra latency.
- Per rising edge, in priority order:
  1. hold=1: all registers keep their value (including ex_valid), the counter is unchanged, and load_use is ignored for counting.
  2. flush=1: load a bubble. No counter increment.
  3. load_use=1: load a bubble and increment bubble_count (saturating at all-ones). The ID instruction stays in ID because upstream is stalled by stall_out.
  4. Otherwise: load all id_* values, set ex_valid=1, and set ex_imm_ext = {{16{id_imm[15]}}, id_imm}.
- Bubble contents: every ex_* output is 0 and ex_valid=0. In particular reg_write, mem_read, mem_write, jump and branch are all 0, so no architectural side effects occur.
- Latency: one cycle from ID inputs to ex_* outputs.
- Don't-care control bits from the decoder (for example reg_dst on sw/j) are registered as driven. The bench compares them only when the decoder drives a defined value.
- A flush and load_use in the same cycle produce one bubble with no count.
- Two back-to-back load-use cycles cannot occur for the same instruction, because the bubble clears ex_valid.

Test Plan:
- Reset mid-operation: after reset, run add then lw, and assert reset mid-stream → all ex_* = 0, ex_valid=0, bubble_count=0 within the same cycle (asynchronous).
- R-type pass-through: opcode 000000, rs=3, rt=4, rd=5, rs_data=0x11, rt_data=0x22 → next edge ex_rd=5, ex_reg_write=1, ex_reg_dst=1, ex_valid=1, stall_out=0.
- Load-use on rs: EX holds lw (mem_read=01, rt=8); ID holds add with rs=8:
  - stall_out=1 in that cycle;
  - the next edge gives ex_valid=0 and bubble_count=1;
  - the following edge loads the add.
- No false hazard:
  - EX holds lw with rt=0 and ID rs=0 → stall_out=0.
  - EX holds lw with rt=9 and ID is lui with rt=9 → stall_out=0.
- Flush priority: flush=1 together with a load-use condition → bubble loaded, bubble_count unchanged. Sign extension is checked separately: id_imm=0x8004 → ex_imm_ext=0xFFFF8004.
- Hold: hold=1 for 3 cycles with changing id_* inputs → ex_* stable and stall_out=1 throughout. The counter saturates at 0xFFFF after forced repeated hazards.
